axi4_stream_pkt_len_filter: RTL and testbench
=============================================

# axi4_stream_pkt_len_filter

Cut-through AXI4-Stream packet length policer placed directly upstream of the store-and-forward packet FIFO. It counts words per packet and truncates over-long packets at `MAX_WORDS`, forcing `tlast` and discarding the rest, so no packet can exceed FIFO capacity. It flags runt and truncated packets in `tuser[0]` on the last word, and keeps saturating statistics. Output is registered through a skid buffer, which decouples `pkt_o.tready` from `pkt_i.tready`.

## Interface
- `DATA_WIDTH`, 32: tdata width in bits; tstrb/tkeep width is `DATA_WIDTH/8`.
- `USER_WIDTH`, 1: tuser width; must be ≥1, since bit 0 is the error flag.
- `DEST_WIDTH`, 1: tdest width.
- `ID_WIDTH`, 1: tid width.
- `MIN_WORDS`, 4: packets with fewer words are runts. A value of 1 disables runt detection.
- `MAX_WORDS`, 64: maximum words passed per packet, ≥2. Set to ≤ downstream FIFO depth in words.
- `CNT_WIDTH`, 16: width of the statistics counters.
- `clk_i`  input  1  single clock; all logic on rising edge.
- `rst_i`  input  1  reset, synchronous, active-high.
- `pkt_i`  `axi4_stream_if.slave`  parameterised  input stream.
- `pkt_o`  `axi4_stream_if.master`  parameterised  output stream, feeds the packet FIFO.
- `pkt_cnt_o`  output  `CNT_WIDTH`  packets emitted (tlast words written to output), saturating.
- `runt_cnt_o`  output  `CNT_WIDTH`  runt packets emitted, saturating.
- `trunc_cnt_o`  output  `CNT_WIDTH`  truncated packets, saturating.

## Operation
- **Word counter** `word_cnt`, width `$clog2(MAX_WORDS+1)`:
  - Holds the 1-based index of the current word.
  - Resets to 0.
  - Clears on acceptance of any word that leaves the output with tlast=1.
- **FSM states: PASS, DROP.**
- **PASS**
  - Input accepted only when the skid buffer has space.
  - All fields are forwarded unchanged except tlast and tuser[0], as follows.
  - **Accepted word with index == `MAX_WORDS` and tlast=0:**
    - emitted with tlast=1 and tuser[0]=1;
    - `trunc_cnt_o` and `pkt_cnt_o` increment;
    - next state DROP.
  - **Accepted word with tlast=1 and index < `MIN_WORDS`:**
    - emitted with tuser[0]=1;
    - `runt_cnt_o` and `pkt_cnt_o` increment.
  - **Accepted word with tlast=1, otherwise:**
    - tuser[0] passed through unchanged;
    - `pkt_cnt_o` increments.
  - Exactly `MAX_WORDS` words with tlast on the last word is a normal packet, with no flag.
- **DROP**
  - `pkt_i.tready` = 1 regardless of output state.
  - Every accepted word is discarded and nothing is emitted.
  - Acceptance of a tlast=1 word returns the FSM to PASS.
  - The word counter stays 0.
- **Counters** saturate at all-ones and never wrap. They are registered and reset to 0.
- **Reset mid-packet:**
  - FSM returns to PASS, the counter goes to 0 and the skid buffer empties.
  - The in-flight output packet is lost.
  - The remainder of the input packet is treated as a new packet.

## Timing
- Reset values:
  - `pkt_o.tvalid`=0;
  - all counter outputs 0;
  - `pkt_i.tready`=0 while `rst_i`=1, and 1 in the first cycle after `rst_i` deasserts.
- **Latency:** a word accepted in cycle N is valid on `pkt_o` in cycle N+1 when the output is idle.
- **Throughput:** 1 word/cycle sustained with `pkt_o.tready`=1.
- **Skid buffer** (2 entries):
  - `pkt_i.tready` (in PASS) is a registered function of occupancy, with no combinational path from `pkt_o.tready`.
  - It deasserts only when both entries are full.
- **AXI rule:** `pkt_o` holds tvalid and all fields stable until tready.
- **Transitions:** the FSM transition and counter updates take effect the cycle after the qualifying acceptance.
- **Simultaneous truncation and tlast** (index == `MAX_WORDS` with tlast=1): treated as a normal packet; FSM stays in PASS.
- **Runt and truncation together** are impossible, given `MAX_WORDS` ≥ `MIN_WORDS`. This relation is checked by elaboration-time assertion.

## Structure
- Package `axi4_stream_pkt_len_filter_pkg`:
  - FSM state enum (`PASS_S`, `DROP_S`);
  - a parameter-independent saturating-increment function.
- The packed word struct (tdata/tstrb/tkeep/tlast/tuser/tdest/tid) is local to the module, because its widths are module parameters.
- One sub-module: `axi4_stream_skid_buf`, a 2-entry registered-ready pipeline stage, parameterised by word width, reusable elsewhere in the library.

## Test plan
- **Nominal:** `MIN_WORDS`=4, `MAX_WORDS`=8, ready=1; send 5-word and 8-word packets.
  - Output is identical.
  - tuser[0]=0.
  - `pkt_cnt_o`=2.
  - Latency is 1 cycle.
- **Truncation:** send a 12-word packet.
  - Output is 8 words, word 8 has tlast=1 and tuser[0]=1.
  - Input words 9–12 are consumed with tready=1 and not emitted.
  - `trunc_cnt_o`=1.
  - The next 5-word packet passes intact.
- **Runt:** send 1-word and 3-word packets.
  - Both are emitted with tuser[0]=1 on the last word.
  - `runt_cnt_o`=2.
- **Backpressure:** random `pkt_o.tready` (50%) over 1000 random packets of length 1–12.
  - No word loss or duplication against the reference model.
  - `pkt_i.tready` never depends combinationally on `pkt_o.tready`.
- **Reset mid-packet:**
  - Assert `rst_i` on word 3 of 6; after release, send remaining words 4–6 then a 5-word packet.
  - Output shows words 4–6 as a runt (tuser[0]=1), then the clean packet.
  - Counters restart from 0.
- **Saturation:** with `CNT_WIDTH`=4, send 20 packets; `pkt_cnt_o` holds at 15.

Source files
------------

// File: rtl/axi4_stream_pkt_len_filter_pkg.sv
// axi4_stream_pkt_len_filter_pkg: shared FSM state type and saturating counter helper
package axi4_stream_pkt_len_filter_pkg;
  typedef enum logic {PASS_S, DROP_S} state_e;
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : (64'(1) << w) - 64'(1);
    return (v >= m) ? v : v + 64'(1);
  endfunction
endpackage

// File: rtl/axi4_stream_if.sv
// axi4_stream_if: parameterised AXI4-Stream bundle with master/slave views
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [ID_WIDTH-1:0]     tid;
  modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid, input tready);
  modport slave (input tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid, output tready);
endinterface

// File: rtl/axi4_stream_skid_buf.sv
// axi4_stream_skid_buf: 2-entry pipeline stage whose input ready is a pure register of occupancy
module axi4_stream_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);
  logic [1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic rdy_q, push, pop;
  always_comb begin
    push = in_valid_i & in_ready_o;
    pop = out_valid_o & out_ready_i;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    head_d = (push && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) ? in_data_i : pop ? tail_q : head_q;
    tail_d = (push && cnt_q == 2'd1 && !pop) ? in_data_i : tail_q;
  end
  // ready is preloaded during reset so it can rise on the very first cycle after release
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      rdy_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= cnt_d != 2'd2;
    end
    head_q <= head_d;
    tail_q <= tail_d;
  end
  assign in_ready_o = rdy_q & ~rst_i;
  assign out_valid_o = cnt_q != 2'd0;
  assign out_data_o = head_q;
endmodule

// File: rtl/axi4_stream_pkt_len_filter.sv
// axi4_stream_pkt_len_filter: truncates over-long packets, flags runts/truncations in tuser[0], keeps stats
module axi4_stream_pkt_len_filter
  import axi4_stream_pkt_len_filter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1,
  parameter int MIN_WORDS  = 4,
  parameter int MAX_WORDS  = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  axi4_stream_if.slave         pkt_i,
  axi4_stream_if.master        pkt_o,
  output logic [CNT_WIDTH-1:0] pkt_cnt_o,
  output logic [CNT_WIDTH-1:0] runt_cnt_o,
  output logic [CNT_WIDTH-1:0] trunc_cnt_o
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int WCW = $clog2(MAX_WORDS + 1);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [KW-1:0]         tstrb;
    logic [KW-1:0]         tkeep;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;
    logic [DEST_WIDTH-1:0] tdest;
    logic [ID_WIDTH-1:0]   tid;
  } word_t;
  if (MAX_WORDS < MIN_WORDS || MAX_WORDS < 2 || MIN_WORDS < 1 || USER_WIDTH < 1) begin : g_bad_params
    $error("axi4_stream_pkt_len_filter: need 1 <= MIN_WORDS <= MAX_WORDS, MAX_WORDS >= 2, USER_WIDTH >= 1");
  end
  state_e state_q, state_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d, idx;
  logic [CNT_WIDTH-1:0] pkt_q, pkt_d, runt_q, runt_d, trunc_q, trunc_d;
  logic skid_ready, acc, pass_acc, trunc, runt, last;
  word_t in_w, out_w;
  always_comb begin
    acc = pkt_i.tvalid & pkt_i.tready;
    pass_acc = acc & (state_q == PASS_S);
    idx = word_cnt_q + WCW'(1);
    trunc = (idx == WCW'(MAX_WORDS)) && !pkt_i.tlast;
    runt = pkt_i.tlast && (idx < WCW'(MIN_WORDS));
    last = pkt_i.tlast | trunc;
    in_w = {pkt_i.tdata, pkt_i.tstrb, pkt_i.tkeep, last, pkt_i.tuser | USER_WIDTH'(trunc | runt), pkt_i.tdest, pkt_i.tid};
    state_d = pass_acc ? (trunc ? DROP_S : PASS_S) : (acc && pkt_i.tlast) ? PASS_S : state_q;
    word_cnt_d = pass_acc ? (last ? '0 : idx) : word_cnt_q;
    pkt_d = (pass_acc && last) ? CNT_WIDTH'(sat_inc(64'(pkt_q), CNT_WIDTH)) : pkt_q;
    runt_d = (pass_acc && runt) ? CNT_WIDTH'(sat_inc(64'(runt_q), CNT_WIDTH)) : runt_q;
    trunc_d = (pass_acc && trunc) ? CNT_WIDTH'(sat_inc(64'(trunc_q), CNT_WIDTH)) : trunc_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= PASS_S;
      word_cnt_q <= '0;
      pkt_q <= '0;
      runt_q <= '0;
      trunc_q <= '0;
    end else begin
      state_q <= state_d;
      word_cnt_q <= word_cnt_d;
      pkt_q <= pkt_d;
      runt_q <= runt_d;
      trunc_q <= trunc_d;
    end
  end
  // while dropping, the tail of an over-long packet is swallowed regardless of output backpressure
  assign pkt_i.tready = (state_q == DROP_S && !rst_i) | skid_ready;
  axi4_stream_skid_buf #(.WIDTH($bits(word_t))) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (pkt_i.tvalid && state_q == PASS_S),
    .in_ready_o (skid_ready),
    .in_data_i  (in_w),
    .out_valid_o(pkt_o.tvalid),
    .out_ready_i(pkt_o.tready),
    .out_data_o (out_w)
  );
  assign {pkt_o.tdata, pkt_o.tstrb, pkt_o.tkeep, pkt_o.tlast, pkt_o.tuser, pkt_o.tdest, pkt_o.tid} = out_w;
  assign pkt_cnt_o = pkt_q;
  assign runt_cnt_o = runt_q;
  assign trunc_cnt_o = trunc_q;
endmodule

// File: tb/tb_axi4_stream_pkt_len_filter.sv
// tb_axi4_stream_pkt_len_filter: scoreboard bench for the packet length policer
module tb_axi4_stream_pkt_len_filter;
  localparam int MIN = 4;
  localparam int MAX = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CW-1:0] pkt_cnt, runt_cnt, trunc_cnt;
  int checks = 0;
  int fails = 0;
  axi4_stream_if #(.DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)) in_if ();
  axi4_stream_if #(.DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)) out_if ();
  axi4_stream_pkt_len_filter #(
    .DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1),
    .MIN_WORDS(MIN), .MAX_WORDS(MAX), .CNT_WIDTH(CW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .pkt_i      (in_if),
    .pkt_o      (out_if),
    .pkt_cnt_o  (pkt_cnt),
    .runt_cnt_o (runt_cnt),
    .trunc_cnt_o(trunc_cnt)
  );
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        u;
    logic [9:0]  side;
  } exp_t;
  exp_t exp_q[$];
  int m_cnt, m_pkt, m_runt, m_trunc;
  bit m_drop;
  int cyc = 0;
  int acc_cyc = -1;
  int out_cyc = -1;
  bit lat_arm = 0;
  bit hold = 0;
  exp_t held;
  bit bp_en = 0;
  int n_comb = 0;
  logic ra, rb;
  logic [31:0] dseq = 32'h100;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // reference model and scoreboard, evaluated mid-cycle for the handshakes of the next edge
  always @(negedge clk) begin
    exp_t o, w, e;
    int idx;
    cyc++;
    o = {out_if.tdata, out_if.tlast, out_if.tuser[0], out_if.tkeep, out_if.tstrb, out_if.tdest, out_if.tid};
    if (rst) begin
      exp_q.delete();
      m_cnt = 0; m_drop = 0; m_pkt = 0; m_runt = 0; m_trunc = 0; hold = 0;
    end else begin
      if (hold) check("out_stable", {19'd0, out_if.tvalid, o}, {19'd0, 1'b1, held});
      hold = out_if.tvalid && !out_if.tready;
      held = o;
      if (out_if.tvalid && out_if.tready) begin
        if (lat_arm && out_cyc < 0) out_cyc = cyc;
        if (exp_q.size() == 0) check("spurious_word", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("tdata", 64'(o.d), 64'(e.d));
          check("tlast", 64'(o.l), 64'(e.l));
          check("tuser0", 64'(o.u), 64'(e.u));
          check("sideband", 64'(o.side), 64'(e.side));
        end
      end
      if (in_if.tvalid && in_if.tready) begin
        if (lat_arm && acc_cyc < 0) acc_cyc = cyc;
        w = {in_if.tdata, in_if.tlast, in_if.tuser[0], in_if.tkeep, in_if.tstrb, in_if.tdest, in_if.tid};
        if (m_drop) m_drop = !w.l;
        else begin
          idx = m_cnt + 1;
          if (!w.l && idx == MAX) begin
            w.l = 1'b1; w.u = 1'b1; m_drop = 1; m_cnt = 0;
            m_trunc = sat(m_trunc); m_pkt = sat(m_pkt);
          end else if (w.l) begin
            if (idx < MIN) begin w.u = 1'b1; m_runt = sat(m_runt); end
            m_cnt = 0; m_pkt = sat(m_pkt);
          end else m_cnt = idx;
          exp_q.push_back(w);
        end
      end
    end
  end

  always @(posedge clk) if (bp_en) begin
    #1;
    out_if.tready = 1'($urandom_range(0, 1));
  end

  // flipping the output ready mid-cycle must never move the input ready
  always @(posedge clk) if (bp_en && !rst && n_comb < 50) begin
    #3;
    ra = in_if.tready;
    out_if.tready = !out_if.tready;
    #1;
    rb = in_if.tready;
    out_if.tready = !out_if.tready;
    check("tready_comb", 64'(rb), 64'(ra));
    n_comb++;
  end

  task automatic send_word(input logic l, input logic u, output int waits);
    logic a;
    waits = 0;
    in_if.tvalid = 1'b1;
    in_if.tdata = dseq;
    dseq++;
    in_if.tlast = l;
    in_if.tuser = u;
    in_if.tkeep = 4'($urandom);
    in_if.tstrb = 4'($urandom);
    in_if.tdest = 1'($urandom);
    in_if.tid = 1'($urandom);
    do begin
      @(negedge clk);
      a = in_if.tready;
      @(posedge clk);
      #1;
      waits++;
    end while (!a && waits < 200);
    if (!a) check("in_accept_timeout", 0, 1);
    in_if.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit rnd);
    int w;
    for (int i = 1; i <= len; i++) begin
      send_word(i == len, rnd ? 1'($urandom) : 1'b0, w);
      if (rnd && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain", 64'(exp_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input int p, input int r, input int t);
    check("pkt_cnt", 64'(pkt_cnt), 64'(p));
    check("runt_cnt", 64'(runt_cnt), 64'(r));
    check("trunc_cnt", 64'(trunc_cnt), 64'(t));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tstrb = '0; in_if.tkeep = '0;
    in_if.tlast = 1'b0; in_if.tuser = '0; in_if.tdest = '0; in_if.tid = '0;
    out_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_if.tready), 0);
    check("rst_out_valid", 64'(out_if.tvalid), 0);
    chk_cnt(0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(in_if.tready), 1);
    @(posedge clk);
    #1;
    lat_arm = 1;
    send_pkt(5, 0);
    send_pkt(8, 0);
    drain();
    check("latency", 64'(out_cyc - acc_cyc), 1);
    lat_arm = 0;
    chk_cnt(2, 0, 0);
    for (int i = 1; i <= 8; i++) send_word(1'b0, 1'b0, w);
    out_if.tready = 1'b0;
    for (int i = 9; i <= 12; i++) begin
      send_word(i == 12, 1'b0, w);
      check("drop_ready", 64'(w), 1);
    end
    out_if.tready = 1'b1;
    drain();
    chk_cnt(3, 0, 1);
    send_pkt(5, 0);
    drain();
    chk_cnt(4, 0, 1);
    send_pkt(1, 0);
    send_pkt(3, 0);
    drain();
    chk_cnt(6, 2, 1);
    send_word(1'b0, 1'b0, w);
    send_word(1'b0, 1'b0, w);
    in_if.tvalid = 1'b1;
    in_if.tdata = dseq;
    in_if.tlast = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_if.tvalid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_cnt(0, 0, 0);
    @(posedge clk);
    #1;
    for (int i = 4; i <= 6; i++) send_word(i == 6, 1'b0, w);
    send_pkt(5, 0);
    drain();
    chk_cnt(2, 1, 0);
    repeat (20) send_pkt(5, 0);
    drain();
    chk_cnt(15, 1, 0);
    bp_en = 1;
    repeat (1000) send_pkt($urandom_range(1, 12), 1);
    bp_en = 0;
    @(posedge clk);
    #2;
    out_if.tready = 1'b1;
    drain();
    chk_cnt(m_pkt, m_runt, m_trunc);
    check("pkt_cnt_sat", 64'(pkt_cnt), 64'(CMAX));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
